// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified memory between the instruction fetch (I)
//   and data load/store (D) requesters. Exactly one memory transaction is in
//   flight at a time. The winning request is registered, presented on the
//   memory request channel, and the response is routed back to its owner.
//   D has priority over I. A starvation counter forces an I grant after
//   STARVE_MAX consecutive lost arbitrations.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_req_*                  fetch request channel (valid/ready/addr)
//   i_resp_*                 fetch response (1-cycle valid pulse + data)
//   d_req_*                  load/store request channel (valid/ready/addr/we/wdata/wstrb)
//   d_resp_*                 load data / store ack (1-cycle valid pulse + data)
//   m_req_*                  memory request channel, fields registered
//   m_resp_*                 memory response (also pulses for a store ack)
//   busy                     a transaction is owned (state is not IDLE)
//
// States
//   IDLE | arbitrate; accept the winner and latch its fields
//   REQ  | present the latched request until the memory accepts it
//   RESP | wait for the memory response and forward it to the owner

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_resp_valid,
  output logic [DATA_W-1:0]   i_resp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_we,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_resp_data,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic [ADDR_W-1:0]   m_req_addr,
  output logic                m_req_we,
  output logic [DATA_W-1:0]   m_req_wdata,
  output logic [DATA_W/8-1:0] m_req_wstrb,
  input  logic                m_resp_valid,
  input  logic [DATA_W-1:0]   m_resp_data,
  output logic                busy
);

  localparam int          STRB_W     = DATA_W / 8;
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                owner_i, owner_i_nxt;   // 1 = fetch owns the transaction
  logic [3:0]          starve_cnt, starve_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic                we_q, we_nxt;
  logic [DATA_W-1:0]   wdata_q, wdata_nxt;
  logic [STRB_W-1:0]   wstrb_q, wstrb_nxt;

  logic                grant_d, grant_i;
  logic                resp_fire;

  // D wins any contest except when fetch has already lost STARVE_MAX times.
  assign grant_d = d_req_valid && !(i_req_valid && (starve_cnt == STARVE_LIM));
  assign grant_i = i_req_valid && !grant_d;

  always_comb begin
    state_nxt    = state;
    owner_i_nxt  = owner_i;
    starve_nxt   = starve_cnt;
    addr_nxt     = addr_q;
    we_nxt       = we_q;
    wdata_nxt    = wdata_q;
    wstrb_nxt    = wstrb_q;
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    m_req_valid  = 1'b0;
    resp_fire    = 1'b0;

    case (state)
      IDLE: begin
        if (grant_d) begin
          d_req_ready = 1'b1;
          owner_i_nxt = 1'b0;
          addr_nxt    = d_req_addr;
          we_nxt      = d_req_we;
          wdata_nxt   = d_req_wdata;
          wstrb_nxt   = d_req_wstrb;
          state_nxt   = REQ;
          // A D win while I waits can only happen below the limit, so this
          // increment saturates at STARVE_MAX by construction.
          if (i_req_valid && (starve_cnt != STARVE_LIM)) begin
            starve_nxt = starve_cnt + 4'd1;
          end
        end else if (grant_i) begin
          i_req_ready = 1'b1;
          owner_i_nxt = 1'b1;
          addr_nxt    = i_req_addr;
          we_nxt      = 1'b0;
          wdata_nxt   = '0;
          wstrb_nxt   = '0;
          starve_nxt  = 4'd0;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        m_req_valid = 1'b1;
        if (m_req_ready) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (m_resp_valid) begin
          resp_fire = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Reset wins over any accept or response in the same cycle.
    if (rst) begin
      i_req_ready = 1'b0;
      d_req_ready = 1'b0;
      resp_fire   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_i    <= 1'b0;
      starve_cnt <= 4'd0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      state      <= state_nxt;
      owner_i    <= owner_i_nxt;
      starve_cnt <= starve_nxt;
      addr_q     <= addr_nxt;
      we_q       <= we_nxt;
      wdata_q    <= wdata_nxt;
      wstrb_q    <= wstrb_nxt;
    end
  end

  assign m_req_addr   = addr_q;
  assign m_req_we     = we_q;
  assign m_req_wdata  = wdata_q;
  assign m_req_wstrb  = wstrb_q;
  assign busy         = (state != IDLE);

  assign i_resp_valid = resp_fire && owner_i;
  assign d_resp_valid = resp_fire && !owner_i;
  assign i_resp_data  = i_resp_valid ? m_resp_data : '0;
  assign d_resp_data  = d_resp_valid ? m_resp_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req_valid = 1'b0, i_req_ready;
  logic [AW-1:0] i_req_addr = '0;
  logic          i_resp_valid;
  logic [DW-1:0] i_resp_data;
  logic          d_req_valid = 1'b0, d_req_ready;
  logic [AW-1:0] d_req_addr = '0;
  logic          d_req_we = 1'b0;
  logic [DW-1:0] d_req_wdata = '0;
  logic [3:0]    d_req_wstrb = '0;
  logic          d_resp_valid;
  logic [DW-1:0] d_resp_data;
  logic          m_req_valid, m_req_ready = 1'b0;
  logic [AW-1:0] m_req_addr;
  logic          m_req_we;
  logic [DW-1:0] m_req_wdata;
  logic [3:0]    m_req_wstrb;
  logic          m_resp_valid = 1'b0;
  logic [DW-1:0] m_resp_data = '0;
  logic          busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_we(m_req_we), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One pending transaction at most; "sent" means the memory took the request.
  bit            run = 1'b0;
  bit            mdl_active = 1'b0, mdl_sent = 1'b0, mdl_owner_i = 1'b0;
  int            mdl_starve = 0;
  logic [AW-1:0] mdl_addr = '0;
  logic          mdl_we = 1'b0;
  logic [DW-1:0] mdl_wdata = '0;
  logic [3:0]    mdl_wstrb = '0;
  bit            e_i_rdy, e_d_rdy, e_i_rv, e_d_rv;
  bit            acc_i = 1'b0, acc_d = 1'b0;

  always @(negedge clk) begin
    if (run) begin
      bit idle, fire;
      idle    = !mdl_active;
      e_d_rdy = !rst && idle && d_req_valid && !(i_req_valid && mdl_starve == SM);
      e_i_rdy = !rst && idle && i_req_valid && !e_d_rdy;
      fire    = !rst && mdl_active && mdl_sent && m_resp_valid;
      e_i_rv  = fire && mdl_owner_i;
      e_d_rv  = fire && !mdl_owner_i;
      chk("i_req_ready",  i_req_ready,  e_i_rdy);
      chk("d_req_ready",  d_req_ready,  e_d_rdy);
      chk("m_req_valid",  m_req_valid,  mdl_active && !mdl_sent);
      chk("busy",         busy,         mdl_active);
      chk("m_req_addr",   m_req_addr,   mdl_addr);
      chk("m_req_we",     m_req_we,     mdl_we);
      chk("m_req_wdata",  m_req_wdata,  mdl_wdata);
      chk("m_req_wstrb",  m_req_wstrb,  mdl_wstrb);
      chk("i_resp_valid", i_resp_valid, e_i_rv);
      chk("d_resp_valid", d_resp_valid, e_d_rv);
      chk("i_resp_data",  i_resp_data,  e_i_rv ? m_resp_data : 32'h0);
      chk("d_resp_data",  d_resp_data,  e_d_rv ? m_resp_data : 32'h0);
    end
  end

  always @(posedge clk) begin
    acc_i = 1'b0;
    acc_d = 1'b0;
    if (rst) begin
      mdl_active = 0; mdl_sent = 0; mdl_owner_i = 0; mdl_starve = 0;
      mdl_addr = '0; mdl_we = 0; mdl_wdata = '0; mdl_wstrb = '0;
    end else if (run) begin
      if (e_d_rdy) begin
        acc_d = 1'b1;
        if (i_req_valid) mdl_starve = (mdl_starve + 1 > SM) ? SM : mdl_starve + 1;
        mdl_active = 1; mdl_sent = 0; mdl_owner_i = 0;
        mdl_addr = d_req_addr; mdl_we = d_req_we; mdl_wdata = d_req_wdata; mdl_wstrb = d_req_wstrb;
      end else if (e_i_rdy) begin
        acc_i = 1'b1;
        mdl_starve = 0;
        mdl_active = 1; mdl_sent = 0; mdl_owner_i = 1;
        mdl_addr = i_req_addr; mdl_we = 0; mdl_wdata = '0; mdl_wstrb = '0;
      end else if (mdl_active && !mdl_sent && m_req_ready) begin
        mdl_sent = 1;
      end else if (mdl_active && mdl_sent && m_resp_valid) begin
        mdl_active = 0;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle-fraction after the edge with the requests already driven.
  task automatic xact(input bit exp_d, input int stall, input logic [31:0] exp_addr,
                      input bit exp_we, input logic [3:0] exp_strb, input logic [31:0] rdata);
    m_req_ready = (stall == 0);
    #1;
    chk("x_d_ready", d_req_ready, exp_d);
    chk("x_i_ready", i_req_ready, !exp_d);
    tick();
    if (exp_d) d_req_valid = 1'b0; else i_req_valid = 1'b0;
    #1;
    chk("x_addr", m_req_addr, exp_addr);
    chk("x_we",   m_req_we,   exp_we);
    chk("x_strb", m_req_wstrb, exp_strb);
    for (int s = 0; s < stall; s++) begin
      chk("x_stall_mv",   m_req_valid, 1'b1);
      chk("x_stall_busy", busy, 1'b1);
      chk("x_stall_rdy",  {i_req_ready, d_req_ready}, 2'b00);
      chk("x_stall_addr", m_req_addr, exp_addr);
      tick();
      #1;
    end
    m_req_ready = 1'b1;
    chk("x_mv", m_req_valid, 1'b1);
    tick();
    m_resp_valid = 1'b1;
    m_resp_data  = rdata;
    #1;
    chk("x_own_rv",   exp_d ? d_resp_valid : i_resp_valid, 1'b1);
    chk("x_own_data", exp_d ? d_resp_data : i_resp_data, rdata);
    chk("x_oth_rv",   exp_d ? i_resp_valid : d_resp_valid, 1'b0);
    chk("x_oth_data", exp_d ? i_resp_data : d_resp_data, 32'h0);
    tick();
    m_resp_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    run = 1'b1;
    #1;
    chk("rst_outputs", {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, m_req_valid, busy}, 6'b0);
    rst = 1'b0;
    tick();

    // I-only read
    i_req_valid = 1; i_req_addr = 32'h100;
    xact(0, 0, 32'h100, 0, 4'h0, 32'hDEADBEEF);

    // simultaneous: D store beats I, then I at the next IDLE
    i_req_valid = 1; i_req_addr = 32'h100;
    d_req_valid = 1; d_req_addr = 32'h200; d_req_we = 1; d_req_wdata = 32'h12345678; d_req_wstrb = 4'hF;
    xact(1, 0, 32'h200, 1, 4'hF, 32'h0);
    xact(0, 0, 32'h100, 0, 4'h0, 32'h11111111);

    // starvation: four D wins, then I, then D again with I waiting
    i_req_valid = 1; i_req_addr = 32'h300;
    for (int k = 0; k < 6; k++) begin
      d_req_valid = 1; d_req_addr = 32'h1000 + 32'(k) * 4; d_req_we = 0; d_req_wstrb = 4'h0;
      if (k == 5) begin i_req_valid = 1; i_req_addr = 32'h304; end
      xact(k != 4, 0, (k == 4) ? 32'h300 : 32'h1000 + 32'(k) * 4, 0, 4'h0, 32'(k));
      if (k == 4) chk("starve_cleared", mdl_starve, 0);
    end
    chk("starve_after_d", mdl_starve, 1);
    xact(0, 0, 32'h304, 0, 4'h0, 32'h22222222);

    // backpressure: three stall cycles with I waiting
    i_req_valid = 1; i_req_addr = 32'h400;
    d_req_valid = 1; d_req_addr = 32'h500; d_req_we = 1; d_req_wdata = 32'hCAFEF00D; d_req_wstrb = 4'h3;
    xact(1, 3, 32'h500, 1, 4'h3, 32'h0);
    xact(0, 0, 32'h400, 0, 4'h0, 32'h33333333);

    // spurious response in IDLE
    m_resp_valid = 1; m_resp_data = 32'h55555555;
    #1;
    chk("spur_rv", {i_resp_valid, d_resp_valid}, 2'b00);
    tick();
    m_resp_valid = 0;

    // reset during RESP, late response ignored
    d_req_valid = 1; d_req_addr = 32'h600; d_req_we = 0; d_req_wstrb = 4'h0; m_req_ready = 1;
    tick();
    d_req_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("post_rst_out", {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, m_req_valid, busy}, 6'b0);
    chk("post_rst_addr", m_req_addr, 32'h0);
    m_resp_valid = 1; m_resp_data = 32'h66666666;
    #1;
    chk("late_resp", {i_resp_valid, d_resp_valid}, 2'b00);
    tick();
    m_resp_valid = 0;

    // load data routing
    d_req_valid = 1; d_req_addr = 32'h40; d_req_we = 0; d_req_wstrb = 4'h0;
    xact(1, 0, 32'h40, 0, 4'h0, 32'hA5A5A5A5);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (acc_i || !i_req_valid) begin
        i_req_valid = ($urandom_range(0, 2) != 0);
        i_req_addr  = $urandom & 32'hFFFF_FFFC;
      end
      if (acc_d || !d_req_valid) begin
        d_req_valid = ($urandom_range(0, 2) != 0);
        d_req_addr  = $urandom;
        d_req_we    = $urandom_range(0, 1);
        d_req_wdata = $urandom;
        d_req_wstrb = d_req_we ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      m_req_ready  = ($urandom_range(0, 2) != 0);
      m_resp_valid = ($urandom_range(0, 2) == 0);
      m_resp_data  = $urandom;
      rst          = ($urandom_range(0, 99) == 0);
    end
    tick();
    rst = 0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
